// File: rtl/peak_batch_scheduler.sv
// Ping-pong batching of per-frame peak frequencies toward the PISO/FIFO/SPI chain.
// The write side fills one bank while the read FSM loads and drains the other.
module peak_batch_scheduler #(
  parameter int N_PEAKS       = 16,
  parameter int FREQ_W        = 9,
  parameter int PAD_W         = 16,
  parameter int DRAIN_TIMEOUT = 64
) (
  input  logic                                clk_i,
  input  logic                                rst_ni,
  input  logic                                peak_valid_i,
  input  logic [FREQ_W-1:0]                   peak_freq_i,
  input  logic                                fifo_full_i,
  input  logic                                piso_active_i,
  output logic                                piso_load_o,
  output logic [N_PEAKS*(FREQ_W+PAD_W)-1:0]   piso_data_o,
  output logic                                busy_o,
  output logic [7:0]                          drop_count_o,
  output logic                                overflow_o
);

  localparam int EW    = FREQ_W + PAD_W;
  localparam int IDX_W = (N_PEAKS > 2) ? $clog2(N_PEAKS) : 1;
  localparam int TMR_W = (DRAIN_TIMEOUT > 2) ? $clog2(DRAIN_TIMEOUT) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_PEAKS - 1);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(DRAIN_TIMEOUT - 1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT_ROOM, S_LOAD, S_DRAIN} state_e;

  state_e             state_q, state_d;
  logic [TMR_W-1:0]   timer_q, timer_d;
  logic               seen_active_q, seen_active_d;
  logic               overflow_q, overflow_d;
  logic               wsel_q, wsel_d;
  logic               rsel_q, rsel_d;
  logic [IDX_W-1:0]   widx_q, widx_d;
  logic [1:0]         bank_full_q, bank_full_d;
  logic [7:0]         drop_count_q, drop_count_d;
  logic [FREQ_W-1:0]  bank_q [2][N_PEAKS];

  logic wr_en, wr_last, drop, drain_done;

  assign wr_en   = peak_valid_i && !bank_full_q[wsel_q];
  assign wr_last = wr_en && (widx_q == IDX_LAST);
  assign drop    = peak_valid_i && bank_full_q[wsel_q];

  always_comb begin
    state_d       = state_q;
    timer_d       = timer_q;
    seen_active_d = seen_active_q;
    overflow_d    = overflow_q;
    drain_done    = 1'b0;
    case (state_q)
      S_IDLE:      if (bank_full_q[rsel_q]) state_d = S_WAIT_ROOM;
      S_WAIT_ROOM: if (!fifo_full_i) state_d = S_LOAD;
      S_LOAD: begin
        timer_d       = '0;
        seen_active_d = 1'b0;
        state_d       = S_DRAIN;
      end
      S_DRAIN: begin
        timer_d = timer_q + 1'b1;
        if (piso_active_i) seen_active_d = 1'b1;
        if (fifo_full_i) overflow_d = 1'b1;
        // Exit on the PISO's falling output_active, or give up at the timeout.
        if ((seen_active_q && !piso_active_i) || (timer_q == TMR_LAST)) begin
          drain_done = 1'b1;
          state_d    = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    wsel_d       = wsel_q;
    widx_d       = widx_q;
    rsel_d       = rsel_q ^ drain_done;
    bank_full_d  = bank_full_q;
    drop_count_d = drop_count_q;
    if (wr_en) begin
      if (wr_last) begin
        bank_full_d[wsel_q] = 1'b1;
        wsel_d              = ~wsel_q;
        widx_d              = '0;
      end else begin
        widx_d = widx_q + 1'b1;
      end
    end
    // Set and clear never hit the same bank: a draining bank is full, a written one is not.
    if (drain_done) bank_full_d[rsel_q] = 1'b0;
    if (drop && (drop_count_q != 8'hFF)) drop_count_d = drop_count_q + 8'd1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= S_IDLE;
      timer_q       <= '0;
      seen_active_q <= 1'b0;
      overflow_q    <= 1'b0;
      wsel_q        <= 1'b0;
      rsel_q        <= 1'b0;
      widx_q        <= '0;
      bank_full_q   <= 2'b00;
      drop_count_q  <= 8'd0;
      for (int b = 0; b < 2; b++)
        for (int i = 0; i < N_PEAKS; i++)
          bank_q[b][i] <= '0;
    end else begin
      state_q       <= state_d;
      timer_q       <= timer_d;
      seen_active_q <= seen_active_d;
      overflow_q    <= overflow_d;
      wsel_q        <= wsel_d;
      rsel_q        <= rsel_d;
      widx_q        <= widx_d;
      bank_full_q   <= bank_full_d;
      drop_count_q  <= drop_count_d;
      if (wr_en) bank_q[wsel_q][widx_q] <= peak_freq_i;
    end
  end

  always_comb begin
    piso_data_o = '0;
    for (int i = 0; i < N_PEAKS; i++)
      piso_data_o[i*EW +: EW] = {bank_q[rsel_q][i], {PAD_W{1'b0}}};
  end

  assign piso_load_o  = (state_q == S_LOAD);
  assign busy_o       = (state_q != S_IDLE);
  assign drop_count_o = drop_count_q;
  assign overflow_o   = overflow_q;

endmodule

// File: tb/tb_peak_batch_scheduler.sv
// Scoreboard bench for peak_batch_scheduler: expected batches are queued at stimulus
// time and checked by a monitor on every piso_load pulse.
module tb_peak_batch_scheduler;
  localparam int NP = 16;
  localparam int FW = 9;
  localparam int PW = 16;
  localparam int EW = FW + PW;
  localparam int DW = NP * EW;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          peak_valid;
  logic [FW-1:0] peak_freq;
  logic          fifo_full;
  logic          piso_active;
  logic          piso_load;
  logic [DW-1:0] piso_data;
  logic          busy;
  logic [7:0]    drop_count;
  logic          overflow;

  peak_batch_scheduler #(.N_PEAKS(NP), .FREQ_W(FW), .PAD_W(PW), .DRAIN_TIMEOUT(64)) dut (
    .clk_i(clk), .rst_ni(rst_n), .peak_valid_i(peak_valid), .peak_freq_i(peak_freq),
    .fifo_full_i(fifo_full), .piso_active_i(piso_active), .piso_load_o(piso_load),
    .piso_data_o(piso_data), .busy_o(busy), .drop_count_o(drop_count), .overflow_o(overflow)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int load_count = 0;
  int load_cyc = 0;
  int last_strobe_cyc = 0;
  int pmode = 0;       // 0: drain after drain_len cycles, 1: stuck high, 2: stuck low
  int drain_len = 16;
  logic [DW-1:0] sb_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] mk(input int base);
    logic [DW-1:0] w;
    w = '0;
    for (int i = 0; i < NP; i++) w[i*EW +: EW] = {FW'(base + i), {PW{1'b0}}};
    return w;
  endfunction

  // Monitor: every load pops the scoreboard and compares the presented batch.
  logic prev_load = 1'b0;
  always @(negedge clk) begin
    if (rst_n && piso_load) begin
      load_count++;
      load_cyc = cyc;
      tests++;
      if (sb_q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_load: load at cycle %0d with no batch queued", cyc);
      end else begin
        logic [DW-1:0] e;
        e = sb_q.pop_front();
        if (piso_data !== e) begin
          fails++;
          $display("FAIL load_data: got %h expected %h", piso_data, e);
        end
      end
      if (prev_load) begin
        tests++;
        fails++;
        $display("FAIL load_width: piso_load high two cycles, expected 1");
      end
    end
    prev_load = piso_load;
  end

  // PISO model, driven on the falling edge.
  int pcnt = 0;
  initial begin
    piso_active = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        pcnt = 0;
        piso_active = 1'b0;
      end else begin
        if (piso_load) pcnt = drain_len;
        case (pmode)
          1:       piso_active = 1'b1;
          2:       piso_active = 1'b0;
          default: begin
            piso_active = (pcnt > 0);
            if (pcnt > 0) pcnt--;
          end
        endcase
      end
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    peak_valid = 1'b0;
    peak_freq = '0;
    fifo_full = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    load_count = 0;
  endtask

  task automatic burst(input int base, input int n);
    @(negedge clk);
    for (int i = 0; i < n; i++) begin
      peak_valid = 1'b1;
      peak_freq = FW'(base + i);
      @(negedge clk);
    end
    peak_valid = 1'b0;
    last_strobe_cyc = cyc;
  endtask

  task automatic wait_loads(input string name, input int n, input int budget);
    int k;
    k = 0;
    while (load_count < n && k < budget) begin
      @(negedge clk);
      k++;
    end
    if (load_count < n) check({name, "_load_timeout"}, load_count, n);
  endtask

  task automatic wait_idle(input string name, input int budget, output int at);
    int k;
    k = 0;
    at = -1;
    while (k < budget) begin
      @(negedge clk);
      k++;
      if (!busy) begin
        at = cyc;
        break;
      end
    end
    if (at < 0) check({name, "_idle_timeout"}, 32'(busy), 0);
  endtask

  int t_idle;
  int t_rel;
  logic [DW-1:0] held;

  initial begin
    rst_n = 1'b0;
    peak_valid = 1'b0;
    peak_freq = '0;
    fifo_full = 1'b0;
    #1;
    check("rst_load", 32'(piso_load), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_drop", 32'(drop_count), 0);
    check("rst_ovf", 32'(overflow), 0);
    check("rst_data_zero", 32'(piso_data != '0), 0);

    // Single batch, sparse strobes.
    do_reset();
    pmode = 0; drain_len = 16;
    sb_q.push_back(mk(1));
    for (int i = 0; i < NP; i++) begin
      burst(1 + i, 1);
      if (i != NP - 1) repeat (199) @(negedge clk);
    end
    wait_loads("single", 1, 20);
    check("single_latency", 32'(load_cyc - last_strobe_cyc), 2);
    wait_idle("single", 100, t_idle);
    check("single_loads", 32'(load_count), 1);
    check("single_active_low", 32'(piso_active), 0);
    check("single_sb_empty", 32'(sb_q.size()), 0);

    // Backpressure.
    do_reset();
    fifo_full = 1'b1;
    sb_q.push_back(mk(40));
    burst(40, NP);
    repeat (50) @(negedge clk);
    check("bp_no_load", 32'(load_count), 0);
    check("bp_busy", 32'(busy), 1);
    fifo_full = 1'b0;
    t_rel = cyc;
    wait_loads("bp", 1, 10);
    check("bp_release_latency", 32'(load_cyc - t_rel), 1);
    wait_idle("bp", 100, t_idle);
    check("bp_overflow", 32'(overflow), 0);

    // Ping-pong, one strobe per cycle.
    do_reset();
    sb_q.push_back(mk(0));
    sb_q.push_back(mk(16));
    burst(0, 2 * NP);
    wait_loads("pp", 2, 200);
    wait_idle("pp", 100, t_idle);
    check("pp_loads", 32'(load_count), 2);
    check("pp_drop", 32'(drop_count), 0);
    check("pp_sb_empty", 32'(sb_q.size()), 0);

    // Drop: PISO never drains, 40 strobes.
    do_reset();
    pmode = 1;
    sb_q.push_back(mk(100));
    burst(100, 40);
    check("drop_loads", 32'(load_count), 1);
    check("drop_count", 32'(drop_count), 8);
    check("drop_bank_full", 32'(dut.bank_full_q), 3);
    held = mk(100);
    check("drop_data_held", 32'(piso_data !== held), 0);

    // Timeout: PISO output_active stays low; DRAIN occupies 64 cycles.
    do_reset();
    pmode = 2;
    sb_q.push_back(mk(300));
    burst(300, NP);
    wait_loads("tmo", 1, 20);
    wait_idle("tmo", 200, t_idle);
    // load seen in LOAD cycle, +1 into DRAIN, +64 DRAIN cycles
    check("tmo_drain_len", 32'(t_idle - load_cyc), 65);
    check("tmo_overflow", 32'(overflow), 0);

    // Overflow: fifo_full pulsed during DRAIN.
    do_reset();
    sb_q.push_back(mk(400));
    burst(400, NP);
    wait_loads("ovf", 1, 20);
    repeat (5) @(negedge clk);
    fifo_full = 1'b1;
    @(negedge clk);
    fifo_full = 1'b0;
    @(negedge clk);
    check("ovf_set", 32'(overflow), 1);
    wait_idle("ovf", 200, t_idle);
    repeat (10) @(negedge clk);
    check("ovf_sticky", 32'(overflow), 1);

    // Reset mid-DRAIN with a partial second bank.
    do_reset();
    check("ovf_cleared", 32'(overflow), 0);
    pmode = 0; drain_len = 40;
    sb_q.push_back(mk(1));
    burst(1, NP);
    wait_loads("mid", 1, 20);
    burst(50, 5);
    check("mid_busy_before", 32'(busy), 1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_busy", 32'(busy), 0);
    check("mid_rst_load", 32'(piso_load), 0);
    check("mid_rst_drop", 32'(drop_count), 0);
    check("mid_rst_data", 32'(piso_data != '0), 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    load_count = 0;
    drain_len = 16;
    sb_q.push_back(mk(200));
    burst(200, NP);
    wait_loads("mid_new", 1, 20);
    wait_idle("mid_new", 100, t_idle);
    repeat (30) @(negedge clk);
    check("mid_new_loads", 32'(load_count), 1);
    check("mid_sb_empty", 32'(sb_q.size()), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end
endmodule
